// File: rtl/srff_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one SR flip-flop.
// Each transaction drives s or r for one cycle, checks q, re-drives up to
// MAX_RETRY times on a mismatch and then acks the requester (with fail set
// if q never reached the requested value). All outputs are registered.
module srff_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_RETRY = 3,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  input  logic            q,
  output logic            s,
  output logic            r,
  output logic [NREQ-1:0] ack,
  output logic            fail,
  output logic            busy,
  output logic [IDW-1:0]  cur_id
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, ACK} state_t;

  state_t          state, state_nxt;
  logic            op_lat, op_lat_nxt;
  logic [RW-1:0]   retry, retry_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt, ptr_inc, base, win, idx;
  logic            found, q_ok, retry_left;
  logic            s_nxt, r_nxt, fail_nxt, busy_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic [IDW-1:0]  cur_nxt;

  assign q_ok       = (q == op_lat);
  assign retry_left = (int'(retry) < MAX_RETRY);

  // Pointer value that takes effect once the current requester is acked.
  always_comb begin
    if (cur_id == IDW'(NREQ - 1)) ptr_inc = '0;
    else                          ptr_inc = cur_id + IDW'(1);
  end

  // Search origin: the grant out of ACK must already skip the requester just served.
  assign base = (state == ACK) ? ptr_inc : ptr;

  // Round-robin pick: first set req bit at or after base, wrapping at NREQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(base) + i) % NREQ);
      if (req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_lat <= 1'b0;
      retry  <= '0;
      ptr    <= '0;
      s      <= 1'b0;
      r      <= 1'b0;
      ack    <= '0;
      fail   <= 1'b0;
      busy   <= 1'b0;
      cur_id <= '0;
    end else begin
      state  <= state_nxt;
      op_lat <= op_lat_nxt;
      retry  <= retry_nxt;
      ptr    <= ptr_nxt;
      s      <= s_nxt;
      r      <= r_nxt;
      ack    <= ack_nxt;
      fail   <= fail_nxt;
      busy   <= busy_nxt;
      cur_id <= cur_nxt;
    end
  end

  // Next-state logic. A request pending during ACK is granted on the ACK exit
  // edge so back-to-back transactions are three cycles apart; with nothing
  // pending the FSM drops to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = DRIVE;
      DRIVE:   state_nxt = CHECK;
      CHECK:   state_nxt = (q_ok || !retry_left) ? ACK : DRIVE;
      ACK:     state_nxt = found ? DRIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath values for the coming cycle, derived from the next state.
  always_comb begin
    op_lat_nxt = op_lat;
    retry_nxt  = retry;
    ptr_nxt    = ptr;
    cur_nxt    = cur_id;
    s_nxt      = 1'b0;
    r_nxt      = 1'b0;
    ack_nxt    = '0;
    fail_nxt   = 1'b0;
    busy_nxt   = (state_nxt != IDLE);
    if ((state == IDLE || state == ACK) && found) begin
      cur_nxt    = win;
      op_lat_nxt = op[win];
      retry_nxt  = '0;
    end
    if (state == ACK) ptr_nxt = ptr_inc;
    if (state == CHECK && state_nxt == DRIVE) retry_nxt = retry + RW'(1);
    if (state == CHECK && state_nxt == ACK) begin
      ack_nxt[cur_id] = 1'b1;
      fail_nxt        = !q_ok;
    end
    // s and r are complements only in DRIVE, zero elsewhere, so never both high.
    if (state_nxt == DRIVE) begin
      s_nxt = op_lat_nxt;
      r_nxt = !op_lat_nxt;
    end
  end

endmodule

// File: tb/tb_srff_arbiter.sv
// Self-checking bench for srff_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_srff_arbiter;
  localparam int N    = 4;
  localparam int MAXR = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req, op;
  logic         q_in;
  logic         s, r, fail, busy;
  logic [N-1:0] ack;
  logic [1:0]   cur_id;
  bit           q_follow;
  int           errors = 0;
  int           checks = 0;

  srff_arbiter #(.NREQ(N), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .q(q_in),
    .s(s), .r(r), .ack(ack), .fail(fail), .busy(busy), .cur_id(cur_id)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge; optionally act as an ideal SR flop.
  task automatic step();
    @(negedge clk);
    if (q_follow) begin
      if (s) q_in = 1'b1;
      else if (r) q_in = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; op = '0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    req = '0; op = '0; q_in = 1'b0; q_follow = 1'b1;
    #1 rst = 1'b0;
    repeat (3) step();
    checks++; if ({s, r, fail, busy} !== 4'b0000) begin errors++; $display("FAIL reset_outs: got s/r/fail/busy=%b expected 0000", {s, r, fail, busy}); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    checks++; if (cur_id !== 2'd0) begin errors++; $display("FAIL reset_cur_id: got %0d expected 0", cur_id); end
    req = 4'b0100;
    step();
    checks++; if (busy !== 1'b0 || r !== 1'b0) begin errors++; $display("FAIL reset_hold_grant: got busy=%b r=%b expected 0 0", busy, r); end
    rst = 1'b1;
    step();
    checks++; if (r !== 1'b1 || s !== 1'b0 || cur_id !== 2'd2) begin errors++; $display("FAIL reset_first_grant: got r=%b s=%b cur_id=%0d expected 1 0 2", r, s, cur_id); end
    step();
    step();
    checks++; if (ack !== 4'b0100 || fail !== 1'b0) begin errors++; $display("FAIL reset_first_ack: got ack=%b fail=%b expected 0100 0", ack, fail); end
    req = '0;
    step();
    checks++; if (busy !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL reset_first_idle: got busy=%b ack=%b expected 0 0000", busy, ack); end
  endtask

  task automatic test_single();
    q_follow = 1'b1; q_in = 1'b0;
    req = 4'b0001; op = 4'b0001;
    step();
    checks++; if (s !== 1'b1 || r !== 1'b0 || busy !== 1'b1 || cur_id !== 2'd0) begin errors++; $display("FAIL single_drive: got s=%b r=%b busy=%b cur_id=%0d expected 1 0 1 0", s, r, busy, cur_id); end
    step();
    checks++; if (s !== 1'b0 || r !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL single_check: got s=%b r=%b ack=%b expected 0 0 0000", s, r, ack); end
    step();
    checks++; if (ack !== 4'b0001 || fail !== 1'b0) begin errors++; $display("FAIL single_ack: got ack=%b fail=%b expected 0001 0", ack, fail); end
    req = '0;
    step();
    checks++; if (ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got ack=%b busy=%b expected 0000 0", ack, busy); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [4];
    logic [N-1:0] exp_seq [4];
    int tim [4];
    int n, t;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000;
    q_follow = 1'b1;
    do_reset();
    op = N'($urandom);
    req = 4'b1111;
    n = 0; t = 0;
    while (n < 4 && t < 40) begin
      step(); t++;
      if (ack != 0) begin
        seq[n] = ack; tim[n] = t; n++;
        req = req & ~ack;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL rr_count: got %0d acks expected 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (seq[i] !== exp_seq[i]) begin errors++; $display("FAIL rr_order[%0d]: got %b expected %b", i, seq[i], exp_seq[i]); end
      if (i > 0) begin
        checks++; if (tim[i] - tim[i-1] != 3) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", i, tim[i] - tim[i-1]); end
      end
    end
    req = '0;
    repeat (3) step();
  endtask

  task automatic test_fairness();
    logic [N-1:0] seq [4];
    int n, t;
    q_follow = 1'b1;
    do_reset();
    op = 4'b0100;
    req = 4'b0101;
    n = 0; t = 0;
    while (n < 4 && t < 40) begin
      step(); t++;
      if (ack != 0) begin
        seq[n] = ack; n++;
        if (n == 4) req = '0;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL fair_count: got %0d acks expected 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (seq[i] !== ((i % 2 == 0) ? 4'b0001 : 4'b0100)) begin errors++; $display("FAIL fair_order[%0d]: got %b expected %b", i, seq[i], (i % 2 == 0) ? 4'b0001 : 4'b0100); end
    end
    req = '0;
    repeat (4) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fair_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_stuck();
    int sp, rp, t;
    bit got;
    logic [N-1:0] ack_seen;
    logic fail_seen;
    q_follow = 1'b0; q_in = 1'b0;
    req = 4'b0010; op = 4'b0010;
    sp = 0; rp = 0; t = 0; got = 1'b0; ack_seen = '0; fail_seen = 1'b0;
    while (!got && t < 30) begin
      step(); t++;
      if (t == 1) op = 4'b0000;
      if (s) sp++;
      if (r) rp++;
      if (ack != 0) begin got = 1'b1; ack_seen = ack; fail_seen = fail; end
    end
    checks++; if (sp != MAXR + 1) begin errors++; $display("FAIL stuck_s_pulses: got %0d expected %0d", sp, MAXR + 1); end
    checks++; if (rp != 0) begin errors++; $display("FAIL stuck_r_pulses: got %0d expected 0", rp); end
    checks++; if (ack_seen !== 4'b0010 || fail_seen !== 1'b1) begin errors++; $display("FAIL stuck_ack: got ack=%b fail=%b expected 0010 1", ack_seen, fail_seen); end
    req = '0;
    repeat (2) step();
    q_follow = 1'b1;
  endtask

  task automatic test_reset_mid();
    int bad;
    q_follow = 1'b1; q_in = 1'b0;
    req = 4'b0001; op = 4'b0001;
    step();
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL rmid_drive: got s=%b expected 1", s); end
    #1 rst = 1'b0;
    #1;
    checks++; if (s !== 1'b0 || r !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000) begin errors++; $display("FAIL rmid_async: got s=%b r=%b busy=%b ack=%b expected 0 0 0 0000", s, r, busy, ack); end
    req = '0;
    repeat (2) step();
    rst = 1'b1;
    bad = 0;
    repeat (6) begin
      step();
      if (ack != 0 || busy) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmid_no_ack: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_early_drop();
    int extra;
    q_follow = 1'b1; q_in = 1'b0;
    req = 4'b1000; op = 4'b1000;
    step();
    checks++; if (s !== 1'b1 || cur_id !== 2'd3) begin errors++; $display("FAIL drop_grant: got s=%b cur_id=%0d expected 1 3", s, cur_id); end
    step();
    req = '0;
    step();
    checks++; if (ack !== 4'b1000 || fail !== 1'b0) begin errors++; $display("FAIL drop_ack: got ack=%b fail=%b expected 1000 0", ack, fail); end
    extra = 0;
    repeat (6) begin
      step();
      if (ack != 0 || s || r) extra++;
    end
    checks++; if (extra != 0 || busy !== 1'b0) begin errors++; $display("FAIL drop_no_repeat: got %0d extra cycles busy=%b expected 0 0", extra, busy); end
  endtask

  // Requesters raise req at random and hold it until acked; the flop ignores
  // a drive one time in four. The model tracks the pending set, its own
  // round-robin pointer and the flop value to predict every grant and ack.
  task automatic test_random();
    logic [N-1:0] req_v, op_v;
    int ptr_m, id_m, exp_id, drives, since, cyc;
    bit in_txn, done_m, exp_busy, found, op_t;
    q_follow = 1'b0;
    do_reset();
    req_v = '0; op_v = '0; ptr_m = 0; id_m = 0; drives = 0; since = 0;
    in_txn = 1'b0; done_m = 1'b0; op_t = 1'b0;
    q_in = 1'($urandom_range(1));
    cyc = 0;
    while (cyc < 3000 && !(cyc >= 600 && !in_txn && req_v == 0)) begin
      @(negedge clk); cyc++;
      exp_busy = in_txn || (req_v != 0);
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy: cycle %0d got %b expected %b", cyc, busy, exp_busy); end
      checks++; if (s && r) begin errors++; $display("FAIL rnd_sr_overlap: cycle %0d got s=1 r=1 expected not both", cyc); end
      checks++; if (ack == 0 && fail !== 1'b0) begin errors++; $display("FAIL rnd_fail_idle: cycle %0d got fail=%b expected 0", cyc, fail); end
      if (s || r) begin
        if (!in_txn) begin
          found = 1'b0; exp_id = 0;
          for (int k = 0; k < N; k++)
            if (!found && req_v[(ptr_m + k) % N]) begin found = 1'b1; exp_id = (ptr_m + k) % N; end
          checks++; if (!found || cur_id !== exp_id[1:0]) begin errors++; $display("FAIL rnd_grant: cycle %0d got cur_id=%0d expected %0d (found=%b)", cyc, cur_id, exp_id, found); end
          in_txn = 1'b1; id_m = exp_id; op_t = op_v[exp_id]; drives = 0; done_m = 1'b0;
        end else begin
          checks++; if (done_m || since != 1) begin errors++; $display("FAIL rnd_retry: cycle %0d got re-drive done=%b gap=%0d expected no success and gap 1", cyc, done_m, since); end
        end
        drives++;
        checks++; if (s !== op_t || r !== !op_t) begin errors++; $display("FAIL rnd_drive_dir: cycle %0d got s=%b r=%b expected %b %b", cyc, s, r, op_t, !op_t); end
        checks++; if (drives > MAXR + 1) begin errors++; $display("FAIL rnd_drive_bound: cycle %0d got %0d drives expected <= %0d", cyc, drives, MAXR + 1); end
        if ($urandom_range(3) != 0) q_in = op_t;
        done_m = (q_in == op_t);
        since = 0;
      end else if (ack != 0) begin
        since++;
        checks++; if (!in_txn || ack !== (4'b0001 << id_m) || since != 2) begin errors++; $display("FAIL rnd_ack: cycle %0d got ack=%b gap=%0d expected %b gap 2", cyc, ack, since, 4'b0001 << id_m); end
        checks++; if (fail !== !done_m) begin errors++; $display("FAIL rnd_fail: cycle %0d got %b expected %b", cyc, fail, !done_m); end
        checks++; if (!done_m && drives != MAXR + 1) begin errors++; $display("FAIL rnd_retries: cycle %0d got %0d drives expected %0d", cyc, drives, MAXR + 1); end
        ptr_m = (id_m + 1) % N; in_txn = 1'b0; req_v[id_m] = 1'b0;
      end else begin
        since++;
        checks++; if (in_txn ? (since > 1) : (req_v != 0)) begin errors++; $display("FAIL rnd_stall: cycle %0d got no activity expected drive or ack (in_txn=%b req=%b)", cyc, in_txn, req_v); end
      end
      if (cyc < 600)
        for (int i = 0; i < N; i++)
          if (!req_v[i] && $urandom_range(3) == 0) begin req_v[i] = 1'b1; op_v[i] = 1'($urandom_range(1)); end
      req = req_v; op = op_v;
    end
    checks++; if (in_txn || req_v != 0) begin errors++; $display("FAIL rnd_drain: got pending=%b in_txn=%b expected all served", req_v, in_txn); end
    req = '0;
  endtask

  initial begin
    req = '0; op = '0; q_in = 1'b0; q_follow = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_stuck();
    test_reset_mid();
    test_early_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
